// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: miss detection and line refill over a req/gnt/rvalid bus for a single-line icache
module icache_fill_ctrl #(
   parameter int ADDR_W     = 64,
   parameter int LINE_BYTES = 16,
   parameter int BUS_W      = 32,
   parameter int OFF_W      = $clog2(LINE_BYTES),
   parameter int BEATS      = LINE_BYTES * 8 / BUS_W,
   parameter int IDX_W      = $clog2(BEATS)
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic [ADDR_W-1:0] fe_pc,
   input  logic              fe_valid,
   input  logic              flush,
   output logic              icache_r,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [BUS_W-1:0]  mem_rdata,
   input  logic              mem_err,
   output logic              fill_we,
   output logic [IDX_W-1:0]  fill_idx,
   output logic [BUS_W-1:0]  fill_data,
   output logic              line_valid,
   output logic [ADDR_W-OFF_W-1:0] line_tag,
   output logic              fill_err
);
   typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;
   state_t state, state_n;
   logic [IDX_W-1:0] cnt;
   logic flush_pend;
   logic miss;
   logic unused_pc_off;
   assign unused_pc_off = ^fe_pc[OFF_W-1:0];
   always_ff @(posedge CLK or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = miss ? REQ : IDLE;
         REQ:     state_n = mem_gnt ? FILL : REQ;
         FILL:    state_n = mem_err ? IDLE : (mem_rvalid && cnt == IDX_W'(BEATS - 1)) ? DONE : FILL;
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      icache_r  = line_valid && fe_pc[ADDR_W-1:OFF_W] == line_tag;
      miss      = state == IDLE && fe_valid && !icache_r;
      fill_we   = state == FILL && mem_rvalid && !mem_err;
      fill_idx  = cnt;
      fill_data = mem_rdata;
   end
   // A flush seen mid-refill is remembered so the finished line is left invalid.
   always_ff @(posedge CLK or negedge reset)
      if (!reset) begin
         line_valid <= 1'b0;
         line_tag   <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         cnt        <= '0;
         fill_err   <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         mem_req    <= state_n == REQ;
         fill_err   <= state == FILL && mem_err;
         cnt        <= state == REQ ? '0 : fill_we ? cnt + 1'b1 : cnt;
         flush_pend <= (state == REQ || (state == FILL && !mem_err)) ? (flush_pend || flush) : 1'b0;
         line_valid <= state == DONE ? !(flush_pend || flush) :
                       (state == IDLE && (flush || miss)) ? 1'b0 : line_valid;
         if (miss) begin
            line_tag <= fe_pc[ADDR_W-1:OFF_W];
            mem_addr <= {fe_pc[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
         end
      end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: randomized refill scenarios checked against a transaction-level line/bus model
module tb_icache_fill_ctrl;
   logic CLK = 1'b0;
   logic reset = 1'b0;
   logic [63:0] fe_pc = '0;
   logic fe_valid = 1'b0, flush = 1'b0;
   logic icache_r, mem_req, fill_we, line_valid, fill_err;
   logic [63:0] mem_addr;
   logic mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
   logic [31:0] mem_rdata = '0, fill_data;
   logic [1:0] fill_idx;
   logic [59:0] line_tag;
   int checks = 0, fails = 0, cyc = 0, errs = 0;
   logic [33:0] wq[$];

   icache_fill_ctrl dut (
      .CLK(CLK), .reset(reset), .fe_pc(fe_pc), .fe_valid(fe_valid), .flush(flush),
      .icache_r(icache_r), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
      .fill_we(fill_we), .fill_idx(fill_idx), .fill_data(fill_data),
      .line_valid(line_valid), .line_tag(line_tag), .fill_err(fill_err)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   always @(negedge CLK) begin
      if (fill_we) wq.push_back({fill_idx, fill_data});
      if (fill_err) errs <= errs + 1;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // One refill of the line holding pc; err_beat>3 means no bus error, fl asserts flush on beat 1.
   task automatic run_fill(input logic [63:0] pc, input int gdly, input int gmax, input int err_beat, input bit fl);
      logic [63:0] ba;
      logic [33:0] exp_q[$];
      int t0, ng, gsum, e0;
      bit aborted;
      ba = {pc[63:4], 4'h0};
      gsum = 0;
      aborted = 0;
      wq.delete();
      e0 = errs;
      fe_pc = pc;
      fe_valid = 1'b1;
      t0 = cyc;
      @(negedge CLK);
      checks++;
      if (icache_r !== 1'b0 || mem_req !== 1'b0) begin
         fails++;
         $display("FAIL miss_cycle icache_r=%b mem_req=%b required 0/0", icache_r, mem_req);
      end
      tick;
      fe_pc = {$urandom, $urandom};
      for (int i = 0; i <= gdly; i++) begin
         mem_gnt = (i == gdly);
         @(negedge CLK);
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== ba || line_tag !== pc[63:4] || line_valid !== 1'b0) begin
            fails++;
            $display("FAIL req_hold mem_req=%b mem_addr=%h tag=%h lv=%b required 1 %h %h 0", mem_req, mem_addr, line_tag, line_valid, ba, pc[63:4]);
         end
         tick;
      end
      mem_gnt = 1'b0;
      @(negedge CLK);
      checks++;
      if (mem_req !== 1'b0) begin
         fails++;
         $display("FAIL req_drop mem_req=%b required 0", mem_req);
      end
      for (int b = 0; b < 4; b++) begin
         ng = gmax > 0 ? $urandom_range(gmax, 0) : 0;
         gsum += ng;
         repeat (ng) tick;
         mem_err = (b == err_beat);
         mem_rvalid = mem_err ? 1'($urandom_range(1, 0)) : 1'b1;
         mem_rdata = $urandom;
         flush = fl && b == 1;
         if (!mem_err) exp_q.push_back({2'(b), mem_rdata});
         else begin
            aborted = 1;
            fe_valid = 1'b0;
         end
         tick;
         mem_rvalid = 1'b0;
         mem_err = 1'b0;
         flush = 1'b0;
         if (aborted) break;
      end
      if (aborted) begin
         @(negedge CLK);
         checks++;
         if (fill_err !== 1'b1 || line_valid !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL err_pulse fill_err=%b lv=%b mem_req=%b required 1 0 0", fill_err, line_valid, mem_req);
         end
         tick;
         @(negedge CLK);
         checks++;
         if (fill_err !== 1'b0 || errs - e0 !== 1) begin
            fails++;
            $display("FAIL err_single fill_err=%b pulses=%0d required 0 1", fill_err, errs - e0);
         end
      end else begin
         fe_pc = pc;
         fe_valid = 1'b0;
         @(negedge CLK);
         checks++;
         if (line_valid !== 1'b0) begin
            fails++;
            $display("FAIL done_cycle line_valid=%b required 0", line_valid);
         end
         tick;
         @(negedge CLK);
         checks++;
         if (icache_r !== !fl || line_valid !== !fl || cyc - t0 !== gdly + gsum + 7) begin
            fails++;
            $display("FAIL hit_after_fill icache_r=%b lv=%b latency=%0d required %b %b %0d", icache_r, line_valid, cyc - t0, !fl, !fl, gdly + gsum + 7);
         end
      end
      checks++;
      if (wq.size() !== exp_q.size()) begin
         fails++;
         $display("FAIL write_count got=%0d required %0d", wq.size(), exp_q.size());
      end else
         foreach (exp_q[k]) begin
            checks++;
            if (wq[k] !== exp_q[k]) begin
               fails++;
               $display("FAIL write_beat%0d got=%h required %h", k, wq[k], exp_q[k]);
            end
         end
      tick;
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if (mem_req !== 0 || mem_addr !== 0 || line_valid !== 0 || line_tag !== 0 || fill_err !== 0 || icache_r !== 0 || fill_we !== 0) begin
         fails++;
         $display("FAIL reset_values req=%b addr=%h lv=%b tag=%h err=%b hit=%b we=%b required all 0", mem_req, mem_addr, line_valid, line_tag, fill_err, icache_r, fill_we);
      end
      @(negedge CLK);
      reset = 1'b1;
      tick;
   endtask

   task automatic test_basic;
      run_fill(64'h1000, 0, 0, 4, 0);
   endtask

   task automatic test_hit;
      fe_pc = 64'h100C;
      fe_valid = 1'b1;
      @(negedge CLK);
      checks++;
      if (icache_r !== 1'b1) begin
         fails++;
         $display("FAIL hit_same_line icache_r=%b required 1", icache_r);
      end
      tick;
      @(negedge CLK);
      checks++;
      if (mem_req !== 1'b0) begin
         fails++;
         $display("FAIL hit_no_req mem_req=%b required 0", mem_req);
      end
      fe_valid = 1'b0;
      tick;
      run_fill(64'h1010, 0, 0, 4, 0);
   endtask

   task automatic test_delayed;
      run_fill(64'h2468, 5, 3, 4, 0);
   endtask

   task automatic test_err_retry;
      run_fill(64'h3000, 1, 1, 2, 0);
      run_fill(64'h3000, 0, 1, 4, 0);
   endtask

   task automatic test_flush;
      run_fill(64'h4000, 2, 1, 4, 1);
      run_fill(64'h4000, 0, 0, 4, 0);
      fe_pc = 64'h4004;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      @(negedge CLK);
      checks++;
      if (icache_r !== 1'b0 || line_valid !== 1'b0) begin
         fails++;
         $display("FAIL flush_idle icache_r=%b lv=%b required 0 0", icache_r, line_valid);
      end
      tick;
   endtask

   task automatic test_reset_mid;
      int n;
      fe_pc = 64'h5000;
      fe_valid = 1'b1;
      tick;
      fe_valid = 1'b0;
      mem_gnt = 1'b1;
      tick;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = $urandom;
      tick;
      mem_rdata = $urandom;
      reset = 1'b0;
      #1;
      checks++;
      if (mem_req !== 0 || line_valid !== 0 || fill_we !== 0 || mem_addr !== 0 || line_tag !== 0) begin
         fails++;
         $display("FAIL reset_mid req=%b lv=%b we=%b addr=%h tag=%h required all 0", mem_req, line_valid, fill_we, mem_addr, line_tag);
      end
      mem_rvalid = 1'b0;
      @(negedge CLK);
      reset = 1'b1;
      tick;
      n = wq.size();
      mem_rvalid = 1'b1;
      @(negedge CLK);
      checks++;
      if (fill_we !== 1'b0 || wq.size() !== n) begin
         fails++;
         $display("FAIL stray_rvalid fill_we=%b writes=%0d required 0 %0d", fill_we, wq.size(), n);
      end
      tick;
      mem_rvalid = 1'b0;
      tick;
   endtask

   task automatic test_random;
      logic [63:0] pc;
      for (int r = 0; r < 10; r++) begin
         pc = {$urandom, $urandom};
         if (line_valid && pc[63:4] == line_tag) pc[4] = ~pc[4];
         run_fill(pc, $urandom_range(4, 0), 2, ($urandom_range(3, 0) == 0) ? $urandom_range(3, 0) : 4,
                  $urandom_range(4, 0) == 0);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_hit;
      test_delayed;
      test_err_retry;
      test_flush;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
